// File: rtl/inst_fetch.sv
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

`ifndef STOP
`define STOP 1'b1
`endif

// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch stage. Issues one instruction-bus request at
//               a time, tolerates wait states, discards data belonging to a
//               flushed fetch, and parks a completed fetch in a hold buffer
//               while decode is stalled.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in             in   1       clock, all state updates on posedge
//   reset_in           in   1       synchronous active-high reset
//   chip_enable_in     in   1       fetch permitted when high
//   pc_in              in   ADDR_W  current PC from the PC stage
//   stall_in           in   6       pipe-ctrl stall vector (bit 1 = decode)
//   jump_flush_in      in   1       branch/jump flush
//   interrupt_flush_in in   1       interrupt flush
//   mem_req_out        out  1       instruction-bus request
//   mem_addr_out       out  ADDR_W  instruction-bus address
//   mem_ack_in         in   1       bus acknowledge, data valid this cycle
//   mem_rdata_in       in   32      bus read data
//   stall_req_out      out  1       fetch-pending stall request
//   id_pc_out          out  ADDR_W  registered PC to decode
//   id_inst_out        out  32      registered instruction to decode
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          ADDR_W   = `ADDR_WIDTH
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              chip_enable_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [5:0]        stall_in,
  input  logic              jump_flush_in,
  input  logic              interrupt_flush_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [31:0]       mem_rdata_in,
  output logic              stall_req_out,
  output logic [ADDR_W-1:0] id_pc_out,
  output logic [31:0]       id_inst_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_req_addr;
  logic [ADDR_W-1:0]   r_hold_pc;
  logic [31:0]         r_hold_inst;

  logic                w_flush;
  logic                w_dec_stop;
  logic                w_req_now;
  logic                w_req_load;
  logic                w_hold_load;
  logic                w_hold_clr;
  logic                w_deliver;
  logic [ADDR_W-1:0]   w_del_pc;
  logic [31:0]         w_del_inst;

  assign w_flush    = jump_flush_in | interrupt_flush_in;
  assign w_dec_stop = (stall_in[1] == `STOP);

  // Next state, bus outputs and the "completed fetch" payload. The payload
  // (w_del_pc/w_del_inst) feeds both the ID registers and the hold buffer;
  // which one takes it depends on the decode stall.
  always_comb begin
    w_next_state  = r_state;
    mem_req_out   = 1'b0;
    mem_addr_out  = r_req_addr;
    stall_req_out = 1'b0;
    w_req_now     = 1'b0;
    w_req_load    = 1'b0;
    w_hold_load   = 1'b0;
    w_hold_clr    = 1'b0;
    w_deliver     = 1'b0;
    w_del_pc      = r_req_addr;
    w_del_inst    = mem_rdata_in;

    case (r_state)
      ST_IDLE: begin
        w_req_now     = chip_enable_in & ~w_flush;
        mem_req_out   = w_req_now;
        mem_addr_out  = pc_in;
        w_req_load    = w_req_now;
        w_del_pc      = pc_in;
        stall_req_out = w_req_now & ~mem_ack_in;
        if (w_req_now) begin
          if (mem_ack_in) begin
            // Zero-wait completion.
            if (w_dec_stop) begin
              w_hold_load  = 1'b1;
              w_next_state = ST_HOLD;
            end else begin
              w_deliver = 1'b1;
            end
          end else begin
            w_next_state = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        mem_req_out   = 1'b1;
        stall_req_out = ~mem_ack_in;
        if (w_flush) begin
          // Ack alongside the flush ends the transfer; otherwise wait it out.
          w_next_state = mem_ack_in ? ST_IDLE : ST_DROP;
        end else if (mem_ack_in) begin
          if (w_dec_stop) begin
            w_hold_load  = 1'b1;
            w_next_state = ST_HOLD;
          end else begin
            w_deliver    = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        // The bus transfer must still complete; its data is discarded.
        mem_req_out   = 1'b1;
        stall_req_out = ~mem_ack_in;
        if (mem_ack_in) begin
          w_next_state = ST_IDLE;
        end
      end

      ST_HOLD: begin
        w_del_pc   = r_hold_pc;
        w_del_inst = r_hold_inst;
        if (w_flush) begin
          w_hold_clr   = 1'b1;
          w_next_state = ST_IDLE;
        end else if (!w_dec_stop) begin
          w_deliver    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    if (reset_in) begin
      mem_req_out   = 1'b0;
      stall_req_out = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= ST_IDLE;
      r_req_addr  <= '0;
      r_hold_pc   <= '0;
      r_hold_inst <= '0;
      id_pc_out   <= '0;
      id_inst_out <= NOP_INST;
    end else begin
      r_state <= w_next_state;

      if (w_req_load) begin
        r_req_addr <= pc_in;
      end

      if (w_hold_load) begin
        r_hold_pc   <= w_del_pc;
        r_hold_inst <= w_del_inst;
      end else if (w_hold_clr) begin
        r_hold_pc   <= '0;
        r_hold_inst <= '0;
      end

      // Flush beats a decode stall; a stalled decode keeps what it has.
      if (w_flush) begin
        id_pc_out   <= '0;
        id_inst_out <= NOP_INST;
      end else if (w_dec_stop) begin
        id_pc_out   <= id_pc_out;
        id_inst_out <= id_inst_out;
      end else if (w_deliver) begin
        id_pc_out   <= w_del_pc;
        id_inst_out <= w_del_inst;
      end else begin
        id_pc_out   <= '0;
        id_inst_out <= NOP_INST;
      end
    end
  end

endmodule

`default_nettype wire
